// File: rtl/svo_cam_axis.sv
// svo_cam_axis: OV7670 RGB565 byte-bus capture, expanded to RGB888 on an AXI4-stream
// through a small first-word-fall-through FIFO (the camera cannot be stalled).
module svo_cam_axis #(
  parameter int SVO_HOR_PIXELS = 640,
  parameter int SVO_VER_PIXELS = 480,
  parameter int SVO_BITS_PER_PIXEL = 24,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cam_pclk_en,
  input  logic                          cam_vsync,
  input  logic                          cam_href,
  input  logic [7:0]                    cam_data,
  output logic                          out_axis_tvalid,
  input  logic                          out_axis_tready,
  output logic [SVO_BITS_PER_PIXEL-1:0] out_axis_tdata,
  output logic                          out_axis_tuser,
  output logic                          overflow,
  output logic                          frame_done
);
  localparam int XW = $clog2(SVO_HOR_PIXELS + 1);
  localparam int YW = $clog2(SVO_VER_PIXELS + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [XW-1:0] X_MAX = XW'(SVO_HOR_PIXELS);
  localparam logic [YW-1:0] Y_MAX = YW'(SVO_VER_PIXELS);
  localparam logic [CW-1:0] D_MAX = CW'(FIFO_DEPTH);
  typedef enum logic [2:0] {SYNC, VBLANK, LINE_WAIT, BYTE_HI, BYTE_LO} state_t;
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [7:0] hi_q, hi_d;
  logic sof_q, sof_d, pushed_q, pushed_d, fd_q, fd_d, pv_q, pv_d, ovf_q;
  logic [SVO_BITS_PER_PIXEL-1:0] pd_q, pd_d;
  logic [SVO_BITS_PER_PIXEL:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  logic [4:0] r5, b5;
  logic [5:0] g6;
  logic pop, wr;
  assign r5 = hi_q[7:3];
  assign g6 = {hi_q[2:0], cam_data[7:5]};
  assign b5 = cam_data[4:0];
  assign pop = (cnt_q != '0) && out_axis_tready;
  assign wr = pv_q && (cnt_q != D_MAX || pop);
  // vsync is honoured from every state; SYNC only differs in never reporting a finished frame
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    hi_d = hi_q;
    pv_d = 1'b0;
    pd_d = pd_q;
    fd_d = 1'b0;
    sof_d = wr ? 1'b0 : sof_q;
    pushed_d = pushed_q | wr;
    if (cam_pclk_en) begin
      if (cam_vsync) begin
        fd_d = (state_q == LINE_WAIT || state_q == BYTE_HI || state_q == BYTE_LO) && pushed_q;
        state_d = VBLANK;
        x_d = '0;
        y_d = '0;
        sof_d = 1'b1;
        pushed_d = 1'b0;
      end else if (state_q == VBLANK) begin
        state_d = LINE_WAIT;
      end else if (state_q != SYNC) begin
        if (!cam_href) begin
          state_d = LINE_WAIT;
          x_d = '0;
          y_d = (x_q != '0 && y_q != Y_MAX) ? y_q + 1'b1 : y_q;
        end else if (state_q == BYTE_LO) begin
          pv_d = x_q < X_MAX && y_q < Y_MAX;
          pd_d = {b5, b5[4:2], g6, g6[5:4], r5, r5[4:2]};
          x_d = (x_q == X_MAX) ? x_q : x_q + 1'b1;
          state_d = BYTE_HI;
        end else begin
          hi_d = cam_data;
          state_d = BYTE_LO;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SYNC;
      x_q <= '0;
      y_q <= '0;
      hi_q <= '0;
      sof_q <= 1'b0;
      pushed_q <= 1'b0;
      fd_q <= 1'b0;
      pv_q <= 1'b0;
      pd_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      hi_q <= hi_d;
      sof_q <= sof_d;
      pushed_q <= pushed_d;
      fd_q <= fd_d;
      pv_q <= pv_d;
      pd_q <= pd_d;
      wp_q <= wr ? wp_q + 1'b1 : wp_q;
      rp_q <= pop ? rp_q + 1'b1 : rp_q;
      cnt_q <= cnt_q + CW'(wr) - CW'(pop);
      ovf_q <= ovf_q | (pv_q && !wr);
    end
  end
  always_ff @(posedge clk) if (wr) mem[wp_q] <= {sof_q, pd_q};
  assign out_axis_tvalid = cnt_q != '0;
  assign out_axis_tdata = mem[rp_q][SVO_BITS_PER_PIXEL-1:0];
  assign out_axis_tuser = out_axis_tvalid && mem[rp_q][SVO_BITS_PER_PIXEL];
  assign overflow = ovf_q;
  assign frame_done = fd_q;
endmodule

// File: tb/tb_svo_cam_axis.sv
// tb_svo_cam_axis: two parameterisations of the capture block driven by one camera stream,
// each checked every cycle against a pixel-queue model built from the line/frame rules.
module tb_svo_cam_axis;
  logic clk = 0, reset = 1, pen = 0, vs = 0, hr = 0, rdy = 1;
  logic [7:0] dat = 0;
  logic req_v = 0;
  logic [23:0] req_pix = 0;
  int req_x = 0, req_y = 0, ly = 0, rdy_mode = 0;
  int checks = 0, passes = 0;
  always #5 clk = ~clk;

  task automatic chk(input int g, input string nm, input logic [24:0] a, input logic [24:0] e);
    checks++;
    if (a === e) passes++;
    else $display("FAIL i%0d %s actual=%h required=%h t=%0t", g, nm, a, e, $time);
  endtask

  function automatic logic [23:0] exp24(input logic [7:0] a, input logic [7:0] b);
    int r, g, bl;
    r = int'(a) >> 3;
    g = ((int'(a) & 7) << 3) | (int'(b) >> 5);
    bl = int'(b) & 31;
    return {8'((bl << 3) | (bl >> 2)), 8'((g << 2) | (g >> 4)), 8'((r << 3) | (r >> 2))};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gm
    localparam int H = g == 0 ? 640 : 4;
    localparam int V = g == 0 ? 480 : 2;
    localparam int D = 16;
    logic tv, tu, ov, fd;
    logic [23:0] td;
    svo_cam_axis #(.SVO_HOR_PIXELS(H), .SVO_VER_PIXELS(V), .SVO_BITS_PER_PIXEL(24), .FIFO_DEPTH(D)) dut (
      .clk(clk), .reset(reset), .cam_pclk_en(pen), .cam_vsync(vs), .cam_href(hr), .cam_data(dat),
      .out_axis_tvalid(tv), .out_axis_tready(rdy), .out_axis_tdata(td), .out_axis_tuser(tu),
      .overflow(ov), .frame_done(fd));
    logic [24:0] q[$];
    logic [24:0] eh = 0;
    logic [23:0] st = 0;
    logic stv = 0, sof = 0, pushed = 0, movf = 0, mfd = 0, ev = 0;
    int phase = 0, beats = 0, sofs = 0, fds = 0;
    always @(posedge clk) begin
      if (tv && rdy) begin beats++; sofs += int'(tu); end
      if (fd) fds++;
      if (reset) begin
        q.delete(); stv = 0; sof = 0; pushed = 0; movf = 0; mfd = 0; phase = 0;
      end else begin
        mfd = pen && vs && phase == 2 && pushed;
        if (q.size() != 0 && rdy) void'(q.pop_front());
        if (stv) begin
          if (q.size() < D) begin q.push_back({sof, st}); sof = 0; pushed = 1; end
          else movf = 1;
        end
        stv = pen && req_v && phase == 2 && !vs && hr && req_x < H && req_y < V;
        st = req_pix;
        if (pen && vs) begin phase = 1; sof = 1; pushed = 0; end
        else if (pen && phase == 1) phase = 2;
      end
      ev = q.size() != 0;
      eh = ev ? q[0] : 25'd0;
    end
  end

  task automatic cmp(input int g, input logic tv, input logic [23:0] td, input logic tu, input logic ov,
                     input logic fd, input logic ev, input logic [24:0] eh, input logic eo, input logic ef);
    chk(g, "tvalid", 25'(tv), 25'(ev));
    if (ev) begin
      chk(g, "tdata", 25'(td), 25'(eh[23:0]));
      chk(g, "tuser", 25'(tu), 25'(eh[24]));
    end
    chk(g, "overflow", 25'(ov), 25'(eo));
    chk(g, "frame_done", 25'(fd), 25'(ef));
  endtask

  always @(negedge clk) begin
    cmp(0, gm[0].tv, gm[0].td, gm[0].tu, gm[0].ov, gm[0].fd, gm[0].ev, gm[0].eh, gm[0].movf, gm[0].mfd);
    cmp(1, gm[1].tv, gm[1].td, gm[1].tu, gm[1].ov, gm[1].fd, gm[1].ev, gm[1].eh, gm[1].movf, gm[1].mfd);
  end

  initial forever begin
    @(posedge clk);
    #1;
    rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'b0 : 1'($urandom);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic v, input logic h, input logic [7:0] d, input logic rv,
                        input logic [23:0] rp, input int rx);
    pen = 1; vs = v; hr = h; dat = d; req_v = rv; req_pix = rp; req_x = rx; req_y = ly;
    tick();
    pen = 0; req_v = 0;
    repeat ($urandom_range(2, 1)) tick();
  endtask

  task automatic vsync(input int n);
    for (int i = 0; i < n; i++) strobe(1, 0, 8'h00, 0, 24'h0, 0);
    ly = 0;
  endtask

  task automatic line(input int np, input bit odd, input bit rnd, input logic [7:0] h,
                      input logic [7:0] l, input bit fin);
    logic [7:0] a, b;
    strobe(0, 0, 8'h00, 0, 24'h0, 0);
    for (int i = 0; i < np; i++) begin
      a = rnd ? 8'($urandom) : h;
      b = rnd ? 8'($urandom) : l;
      strobe(0, 1, a, 0, 24'h0, 0);
      strobe(0, 1, b, 1, exp24(a, b), i);
    end
    if (odd) strobe(0, 1, 8'($urandom), 0, 24'h0, 0);
    if (fin) strobe(0, 0, 8'h00, 0, 24'h0, 0);
    if (np > 0) ly++;
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 0;
    repeat (3) tick();
    while ((gm[0].ev || gm[1].ev) && n < 500) begin tick(); n++; end
    chk(-1, "drain_timeout", 25'(n < 500), 25'd1);
    repeat (3) tick();
  endtask

  initial begin
    int b0, b1, s0, f0;
    chk(-1, "pin_red", 25'(exp24(8'hF8, 8'h00)), 25'h0000FF);
    chk(-1, "pin_green", 25'(exp24(8'h07, 8'hE0)), 25'h00FF00);
    chk(-1, "pin_blue", 25'(exp24(8'h00, 8'h1F)), 25'hFF0000);
    chk(-1, "pin_mid", 25'(exp24(8'h84, 8'h10)), 25'h848284);
    repeat (3) tick();
    reset = 0;
    tick();
    chk(0, "reset_tvalid", 25'(gm[0].tv), 25'd0);
    chk(0, "reset_overflow", 25'(gm[0].ov), 25'd0);
    b0 = gm[0].beats; b1 = gm[1].beats; s0 = gm[0].sofs; f0 = gm[0].fds;
    vsync(3);
    line(4, 0, 0, 8'hF8, 8'h00, 1);
    line(4, 0, 0, 8'hF8, 8'h00, 1);
    vsync(3);
    drain();
    chk(0, "red_beats", 25'(gm[0].beats - b0), 25'd8);
    chk(1, "red_beats", 25'(gm[1].beats - b1), 25'd8);
    chk(0, "red_sof_count", 25'(gm[0].sofs - s0), 25'd1);
    chk(0, "red_frame_done", 25'(gm[0].fds - f0), 25'd1);
    b0 = gm[0].beats; b1 = gm[1].beats;
    line(1, 0, 0, 8'h07, 8'hE0, 1);
    line(1, 0, 0, 8'h00, 8'h1F, 1);
    line(1, 0, 0, 8'h84, 8'h10, 1);
    vsync(3);
    drain();
    chk(0, "colour_beats", 25'(gm[0].beats - b0), 25'd3);
    chk(1, "colour_beats_vclip", 25'(gm[1].beats - b1), 25'd2);
    b0 = gm[0].beats; b1 = gm[1].beats;
    rdy_mode = 1;
    line(40, 0, 1, 8'h00, 8'h00, 1);
    repeat (5) tick();
    chk(0, "ovf_set", 25'(gm[0].ov), 25'd1);
    chk(1, "ovf_clear_hclip", 25'(gm[1].ov), 25'd0);
    drain();
    chk(0, "ovf_beats", 25'(gm[0].beats - b0), 25'd16);
    chk(1, "ovf_beats_hclip", 25'(gm[1].beats - b1), 25'd4);
    s0 = gm[0].sofs;
    vsync(3);
    line(2, 0, 1, 8'h00, 8'h00, 1);
    drain();
    chk(0, "post_ovf_sof", 25'(gm[0].sofs - s0), 25'd1);
    b0 = gm[0].beats; b1 = gm[1].beats;
    vsync(3);
    line(3, 1, 1, 8'h00, 8'h00, 1);
    line(2, 0, 1, 8'h00, 8'h00, 1);
    drain();
    chk(0, "odd_beats", 25'(gm[0].beats - b0), 25'd5);
    chk(1, "odd_beats", 25'(gm[1].beats - b1), 25'd5);
    b0 = gm[0].beats; b1 = gm[1].beats;
    vsync(3);
    for (int i = 0; i < 3; i++) line(6, 0, 1, 8'h00, 8'h00, 1);
    vsync(3);
    drain();
    chk(0, "clip_beats_full", 25'(gm[0].beats - b0), 25'd18);
    chk(1, "clip_beats", 25'(gm[1].beats - b1), 25'd8);
    chk(1, "clip_no_ovf", 25'(gm[1].ov), 25'd0);
    rdy_mode = 1;
    line(5, 0, 1, 8'h00, 8'h00, 0);
    repeat (4) tick();
    chk(0, "mid_buffered", 25'(gm[0].tv), 25'd1);
    reset = 1;
    tick();
    reset = 0;
    chk(0, "mid_reset_tvalid", 25'(gm[0].tv), 25'd0);
    chk(0, "mid_reset_ovf", 25'(gm[0].ov), 25'd0);
    rdy_mode = 0;
    b0 = gm[0].beats; s0 = gm[0].sofs;
    line(3, 0, 1, 8'h00, 8'h00, 1);
    drain();
    chk(0, "no_sync_beats", 25'(gm[0].beats - b0), 25'd0);
    vsync(3);
    line(2, 0, 1, 8'h00, 8'h00, 1);
    vsync(3);
    drain();
    chk(0, "resync_beats", 25'(gm[0].beats - b0), 25'd2);
    chk(0, "resync_sof", 25'(gm[0].sofs - s0), 25'd1);
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      vsync($urandom_range(3, 1));
      for (int l = 0; l < int'($urandom_range(4, 0)); l++)
        line($urandom_range(12, 0), 1'($urandom), 1, 8'h00, 8'h00, 1);
    end
    vsync(2);
    drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
